dm_arbiter: RTL and testbench

- Two-requester arbiter for the shared 32-bit data memory (12-bit address, synchronous write-enable).
- Port 0 is the CPU datapath. Port 1 is the external loader/debug master.
- Uses round-robin arbitration with an optional lock for multi-word bursts, bounded by a hold counter.
- Registers the memory command and returns read data tagged to the owning port after a fixed latency.

---
 rtl/dm_arbiter.sv | 127 ++++++++++++
 tb/tb_dm_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter for the shared data memory, with bounded
// burst locking, a registered memory command and port-tagged read return.
module dm_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} own_e;

  localparam logic [8:0] MAXH = 9'(MAX_HOLD);

  own_e        r_owner, w_owner_nxt;
  logic        r_last, w_last_nxt;
  logic [7:0]  r_hold, w_hold_nxt;
  logic        w_acc0, w_acc1, w_acc, w_lock;

  logic [RD_LAT:0] r_vld_pipe;
  logic [RD_LAT:0] r_port_pipe;
  logic            r_rvalid0, r_rvalid1;
  logic [DW-1:0]   r_rdata;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_lock      = 1'b0;
    if (!rst) begin
      case (r_owner)
        OWN_NONE: begin
          // On a tie the port that was not served last wins.
          if (req0 && req1) begin
            gnt0 = r_last;
            gnt1 = ~r_last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        OWN_P0:  gnt0 = req0;
        OWN_P1:  gnt1 = req1;
        default: ;
      endcase
    end
    w_acc0 = req0 & gnt0;
    w_acc1 = req1 & gnt1;
    w_acc  = w_acc0 | w_acc1;
    if (w_acc) begin
      w_last_nxt = w_acc1;
      w_lock     = w_acc1 ? lock1 : lock0;
      // Keep ownership only while the burst stays under the hold bound.
      if (w_lock && (({1'b0, r_hold} + 9'd1) < MAXH)) begin
        w_owner_nxt = w_acc1 ? OWN_P1 : OWN_P0;
        w_hold_nxt  = r_hold + 8'd1;
      end else begin
        w_owner_nxt = OWN_NONE;
        w_hold_nxt  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_last      <= 1'b1;
      r_hold      <= 8'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_vld_pipe  <= '0;
      r_port_pipe <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_hold   <= w_hold_nxt;
      r_mem_we <= w_acc & (w_acc1 ? we1 : we0);
      if (w_acc) begin
        r_mem_addr  <= w_acc1 ? addr1 : addr0;
        r_mem_wdata <= w_acc1 ? wdata1 : wdata0;
      end
      r_vld_pipe  <= {r_vld_pipe[RD_LAT-1:0], w_acc & ~(w_acc1 ? we1 : we0)};
      r_port_pipe <= {r_port_pipe[RD_LAT-1:0], w_acc1};
      r_rvalid0   <= r_vld_pipe[RD_LAT] & ~r_port_pipe[RD_LAT];
      r_rvalid1   <= r_vld_pipe[RD_LAT] &  r_port_pipe[RD_LAT];
      if (r_vld_pipe[RD_LAT]) r_rdata <= mem_rdata;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (owner/last/hold, shadow memory, read queue).
module tb_dm_arbiter;
  localparam int AW = 12, DW = 32, RD_LAT = 3, MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  logic req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;

  dm_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with RD_LAT cycles from registered command to data.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:RD_LAT-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rpipe[0] <= ram[mem_addr];
    for (int j = 1; j < RD_LAT; j++) rpipe[j] <= rpipe[j-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // Reference model state
  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
  rd_t q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int owner, last, hold, cyc, acc_port;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wd;
  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: check grants, apply the model at the edge, check registered outputs.
  task automatic cycle();
    logic e0, e1, w, l, ev0, ev1;
    logic [AW-1:0] a;
    logic [DW-1:0] d, ed;
    int p;
    e0 = 1'b0; e1 = 1'b0;
    if (!rst) begin
      if (owner < 0) begin
        if (req0 && req1) begin e0 = (last == 1); e1 = (last == 0); end
        else begin e0 = req0; e1 = req1; end
      end else if (owner == 0) e0 = req0;
      else e1 = req1;
    end
    #1;
    chk("gnt0", gnt0, e0);
    chk("gnt1", gnt1, e1);
    @(posedge clk);
    cyc++;
    acc_port = -1;
    if (rst) begin
      owner = -1; last = 1; hold = 0;
      x_we = 0; x_addr = '0; x_wd = '0;
      q.delete();
    end else begin
      x_we = 0;
      if ((req0 && e0) || (req1 && e1)) begin
        p = (req0 && e0) ? 0 : 1;
        acc_port = p;
        w = p ? we1 : we0;  l = p ? lock1 : lock0;
        a = p ? addr1 : addr0;  d = p ? wdata1 : wdata0;
        last = p;
        if (l && hold + 1 < MAX_HOLD) begin owner = p; hold++; end
        else begin owner = -1; hold = 0; end
        x_we = w; x_addr = a; x_wd = d;
        if (w) shadow[a] = d;
        else q.push_back('{cyc + RD_LAT + 1, p, shadow[a]});
      end
    end
    #1;
    chk("mem_we", mem_we, x_we);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_wdata", mem_wdata, x_wd);
    ev0 = 0; ev1 = 0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev0 = (q[0].port == 0); ev1 = (q[0].port == 1); ed = q[0].data;
      void'(q.pop_front());
    end
    chk("rvalid0", rvalid0, ev0);
    chk("rvalid1", rvalid1, ev1);
    if (ev0 || ev1) chk("rdata", rdata, ed);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req0 = 0; req1 = 0;
    repeat (n) cycle();
  endtask

  int cnt0, p1seen, nacc1;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; acc_port = -1;
    owner = -1; last = 1; hold = 0; x_we = 0; x_addr = '0; x_wd = '0;
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i] = i * 32'h9E3779B9 ^ 32'h5A5A_0F0F;
      shadow[i] = ram[i];
    end
    for (int j = 0; j < RD_LAT; j++) rpipe[j] = '0;
    rst = 1; req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    @(negedge clk);
    cycle(); cycle();
    rst = 0;

    // Both ports reading continuously: grants alternate, returns alternate.
    req0 = 1; we0 = 0; addr0 = 12'h010;
    req1 = 1; we1 = 0; addr1 = 12'h020;
    repeat (8) cycle();
    idle(RD_LAT + 2);

    // Port 1 write then read of the same address.
    req1 = 1; we1 = 1; addr1 = 12'h3FF; wdata1 = 32'hDEADBEEF;
    cycle();
    we1 = 0;
    cycle();
    chk("wr_rd_acc", acc_port, 1);
    idle(RD_LAT + 2);

    // Locked burst of 12 writes by port 0 with port 1 waiting.
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 12'h100; wdata0 = $urandom;
    req1 = 1; we1 = 0; lock1 = 0; addr1 = 12'h200;
    cnt0 = 0; p1seen = -1;
    repeat (24) begin
      cycle();
      if (acc_port == 0) begin
        cnt0++;
        if (cnt0 == 12) req0 = 0;
        else begin addr0 = addr0 + 1; wdata0 = $urandom; if (cnt0 == 11) lock0 = 0; end
      end else if (acc_port == 1) begin
        if (p1seen < 0) p1seen = cnt0;
        req1 = 0;
      end
    end
    chk("burst_p1_after", p1seen, MAX_HOLD);
    chk("burst_total", cnt0, 12);
    idle(RD_LAT + 2);

    // Owner idles with lock held: the other port must stay blocked.
    req0 = 1; we0 = 1; lock0 = 1; addr0 = 12'h055; wdata0 = 32'h1234_5678;
    cycle();
    chk("lock_acc", acc_port, 0);
    req0 = 0; req1 = 1; we1 = 0; addr1 = 12'h066;
    nacc1 = 0;
    repeat (3) begin cycle(); if (acc_port == 1) nacc1++; end
    chk("lock_block", nacc1, 0);
    req0 = 1; lock0 = 0; wdata0 = 32'h8765_4321;
    cycle();
    chk("unlock_acc", acc_port, 0);
    req0 = 0;
    cycle();
    chk("after_unlock", acc_port, 1);
    idle(RD_LAT + 2);

    // Reset with a read in flight drops it; first tie afterwards goes to port 0.
    req0 = 1; we0 = 0; addr0 = 12'h010;
    cycle();
    req0 = 0; rst = 1;
    cycle();
    rst = 0; req0 = 1; req1 = 1; we1 = 0; addr1 = 12'h020;
    cycle();
    chk("tie_after_rst", acc_port, 0);
    idle(RD_LAT + 3);

    // Single read by port 1 alone.
    req1 = 1; we1 = 0; lock1 = 0; addr1 = 12'hABC;
    cycle();
    chk("solo_acc", acc_port, 1);
    idle(RD_LAT + 3);

    // Random traffic, small address window to create read-after-write hazards.
    for (int i = 0; i < 3000; i++) begin
      if (!req0 || acc_port == 0) begin
        req0 = ($urandom % 4) != 0; we0 = $urandom % 2; lock0 = ($urandom % 3) == 0;
        addr0 = 12'($urandom % 16); wdata0 = $urandom;
      end
      if (!req1 || acc_port == 1) begin
        req1 = ($urandom % 4) != 0; we1 = $urandom % 2; lock1 = ($urandom % 3) == 0;
        addr1 = 12'($urandom % 16); wdata1 = $urandom;
      end
      rst = ($urandom % 80) == 0;
      cycle();
    end
    rst = 0;
    idle(RD_LAT + 3);
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
